// File: rtl/i2c_pkg.sv
// Shared types, constants and pin-level decode for the WM8731 I2C write engine.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} i2c_state_e;

  typedef logic [1:0] quarter_t;

  localparam logic [6:0]  WM8731_ADDR = 7'h1A;
  localparam int unsigned I2C_BYTES   = 3;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FRAME_W     = 24;

  // SCL level and SDA pull-down for a given state/quarter; returns {scl, sda_low}.
  function automatic logic [1:0] pin_levels(input i2c_state_e st, input quarter_t q,
                                            input logic bit_val);
    logic scl;
    logic sda_low;
    scl     = 1'b1;
    sda_low = 1'b0;
    case (st)
      START: begin
        scl     = (q != 2'd3);
        sda_low = (q >= 2'd2);
      end
      BIT: begin
        scl     = (q == 2'd1) || (q == 2'd2);
        sda_low = ~bit_val;
      end
      ACK: begin
        scl     = (q == 2'd1) || (q == 2'd2);
        sda_low = 1'b0;
      end
      STOP: begin
        scl     = (q != 2'd0);
        sda_low = (q != 2'd3);
      end
      default: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
    endcase
    return {scl, sda_low};
  endfunction

endpackage

// File: rtl/i2c_wm8731_master_if.sv
// Sequencer-facing handshake between the codec configuration sequencer and the I2C engine.
interface i2c_wm8731_master_if;
  import i2c_pkg::*;

  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic              busy_o;
  logic              done_o;
  logic              nack_o;

  modport master (output start_i, output data_i, input busy_o, input done_o, input nack_o);
  modport slave  (input start_i, input data_i, output busy_o, output done_o, output nack_o);

endinterface

// File: rtl/i2c_quarter_tick.sv
// DIV-cycle prescaler and 2-bit quarter counter pacing the SCL waveform.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic     clk_i2c,
  input  logic     reg_rstn,
  input  logic     en,
  input  logic     clr,
  output quarter_t q,
  output logic     tick_c
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] div_cnt;

  assign tick_c = en && (div_cnt == CNT_W'(DIV - 1));

  // Count DIV cycles per quarter; clear realigns both counters on a new transfer.
  always_ff @(posedge clk_i2c or negedge reg_rstn) begin
    if (!reg_rstn) begin
      div_cnt <= '0;
      q       <= '0;
    end else if (clr) begin
      div_cnt <= '0;
      q       <= '0;
    end else if (en) begin
      if (tick_c) begin
        div_cnt <= '0;
        q       <= q + 2'd1;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_wm8731_master.sv
// Write-only single-master I2C engine: sends {DEV_ADDR,W}, data[15:8], data[7:0] with ACK checks.
module i2c_wm8731_master
  import i2c_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter logic [6:0]  DEV_ADDR = WM8731_ADDR
) (
  input  logic                clk_i2c,
  input  logic                reg_rstn,
  i2c_wm8731_master_if.slave  bus,
  output logic                scl_o,
  output logic                sda_low_o,
  input  logic                sda_i
);

  i2c_state_e         state;
  logic [FRAME_W-1:0] shift;
  logic [2:0]         bit_cnt;
  logic [1:0]         byte_cnt;
  logic               busy_r;
  logic               done_r;
  logic               nack_r;

  quarter_t q;
  quarter_t q_n;
  logic     tick_c;
  logic     tick_en;
  logic     accept;
  logic     q_end;

  assign accept  = (state == IDLE) && bus.start_i;
  assign tick_en = (state == START) || (state == BIT) || (state == ACK) || (state == STOP);
  assign q_end   = tick_c && (q == 2'd3);
  assign q_n     = tick_c ? q + 2'd1 : q;

  assign bus.busy_o = busy_r;
  assign bus.done_o = done_r;
  assign bus.nack_o = nack_r;

  i2c_quarter_tick #(.DIV(DIV)) u_tick (
    .clk_i2c  (clk_i2c),
    .reg_rstn (reg_rstn),
    .en       (tick_en),
    .clr      (accept),
    .q        (q),
    .tick_c   (tick_c)
  );

  // Transfer FSM; pins are registered from the state/quarter being entered so they align with it.
  always_ff @(posedge clk_i2c or negedge reg_rstn) begin
    if (!reg_rstn) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      nack_r    <= 1'b0;
      scl_o     <= 1'b1;
      sda_low_o <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          {scl_o, sda_low_o} <= pin_levels(IDLE, 2'd0, 1'b0);
          if (accept) begin
            state              <= START;
            shift              <= {DEV_ADDR, 1'b0, bus.data_i};
            bit_cnt            <= 3'd7;
            byte_cnt           <= 2'd0;
            busy_r             <= 1'b1;
            nack_r             <= 1'b0;
            {scl_o, sda_low_o} <= pin_levels(START, 2'd0, 1'b0);
          end
        end
        START: begin
          if (q_end) begin
            state              <= BIT;
            {scl_o, sda_low_o} <= pin_levels(BIT, 2'd0, shift[FRAME_W-1]);
          end else begin
            {scl_o, sda_low_o} <= pin_levels(START, q_n, 1'b0);
          end
        end
        BIT: begin
          if (q_end) begin
            shift <= {shift[FRAME_W-2:0], 1'b0};
            if (bit_cnt == 3'd0) begin
              state              <= ACK;
              {scl_o, sda_low_o} <= pin_levels(ACK, 2'd0, 1'b0);
            end else begin
              bit_cnt            <= bit_cnt - 3'd1;
              {scl_o, sda_low_o} <= pin_levels(BIT, 2'd0, shift[FRAME_W-2]);
            end
          end else begin
            {scl_o, sda_low_o} <= pin_levels(BIT, q_n, shift[FRAME_W-1]);
          end
        end
        ACK: begin
          // Sample the slave's ACK at the end of the second SCL-high quarter.
          if (tick_c && (q == 2'd2) && sda_i) begin
            nack_r <= 1'b1;
          end
          if (q_end) begin
            if (!nack_r && (byte_cnt < 2'(I2C_BYTES - 1))) begin
              state              <= BIT;
              byte_cnt           <= byte_cnt + 2'd1;
              bit_cnt            <= 3'd7;
              {scl_o, sda_low_o} <= pin_levels(BIT, 2'd0, shift[FRAME_W-1]);
            end else begin
              state              <= STOP;
              {scl_o, sda_low_o} <= pin_levels(STOP, 2'd0, 1'b0);
            end
          end else begin
            {scl_o, sda_low_o} <= pin_levels(ACK, q_n, 1'b0);
          end
        end
        STOP: begin
          if (q_end) begin
            state              <= DONE;
            {scl_o, sda_low_o} <= pin_levels(DONE, 2'd0, 1'b0);
          end else begin
            {scl_o, sda_low_o} <= pin_levels(STOP, q_n, 1'b0);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= ~nack_r;
        end
        default: begin
          state              <= IDLE;
          busy_r             <= 1'b0;
          {scl_o, sda_low_o} <= pin_levels(IDLE, 2'd0, 1'b0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wm8731_master.sv
// Directed bench for i2c_wm8731_master: DIV=1 and DIV=4 instances, wire decoder and ACKing codec model.
module tb_i2c_wm8731_master;

  logic clk_i2c = 1'b0;
  logic reg_rstn;
  always #5 clk_i2c = ~clk_i2c;

  i2c_wm8731_master_if bus1();
  i2c_wm8731_master_if bus4();

  logic scl1, sda_low1, sda_i1;
  logic scl4, sda_low4, sda_i4;
  logic use4 = 1'b1;
  logic start_drv = 1'b0;
  logic codec_pull = 1'b0;
  logic [15:0] data_drv = 16'h0000;

  assign bus1.start_i = start_drv & ~use4;
  assign bus4.start_i = start_drv & use4;
  assign bus1.data_i  = data_drv;
  assign bus4.data_i  = data_drv;
  assign sda_i1 = ~(sda_low1 | (codec_pull & ~use4));
  assign sda_i4 = ~(sda_low4 | (codec_pull & use4));

  logic scl_m, sda_low_m, sda_line, busy_m, done_m, nack_m;
  assign scl_m     = use4 ? scl4 : scl1;
  assign sda_low_m = use4 ? sda_low4 : sda_low1;
  assign sda_line  = use4 ? sda_i4 : sda_i1;
  assign busy_m    = use4 ? bus4.busy_o : bus1.busy_o;
  assign done_m    = use4 ? bus4.done_o : bus1.done_o;
  assign nack_m    = use4 ? bus4.nack_o : bus1.nack_o;

  i2c_wm8731_master #(.DIV(1)) dut1 (
    .clk_i2c(clk_i2c), .reg_rstn(reg_rstn), .bus(bus1),
    .scl_o(scl1), .sda_low_o(sda_low1), .sda_i(sda_i1)
  );

  i2c_wm8731_master #(.DIV(4)) dut4 (
    .clk_i2c(clk_i2c), .reg_rstn(reg_rstn), .bus(bus4),
    .scl_o(scl4), .sda_low_o(sda_low4), .sda_i(sda_i4)
  );

  int vec = 0;
  int errs = 0;

  // Observations from the most recent transfer.
  logic [7:0] rx [4];
  int   rx_n, busy_cyc, done_cnt, start_cnt, stop_cnt, hi_min, hi_max;
  logic first_busy, first_nack, done_end, timed_out;

  // Start (or continue) one transfer, decode the wire and act as the codec until busy_o falls.
  task automatic xfer(input logic [15:0] d, input int nack_slot, input bit spam,
                      input bit skip_start, input bit chain, input logic [15:0] chain_d);
    int bit_idx, hi_cnt;
    bit hi_valid;
    logic [7:0] cur;
    logic prev_scl, prev_sda, s_scl, s_sda;
    for (int i = 0; i < 4; i++) rx[i] = 8'h00;
    rx_n = 0; busy_cyc = 0; done_cnt = 0; start_cnt = 0; stop_cnt = 0;
    hi_min = 1000000; hi_max = 0; timed_out = 1'b0;
    bit_idx = 0; hi_cnt = 0; hi_valid = 1'b0; cur = 8'h00;
    prev_scl = 1'b1; prev_sda = 1'b1; codec_pull = 1'b0;
    if (!skip_start) begin
      data_drv = d;
      start_drv = 1'b1;
    end
    @(negedge clk_i2c);
    start_drv = 1'b0;
    first_busy = busy_m;
    first_nack = nack_m;
    forever begin
      s_scl = scl_m;
      s_sda = sda_line;
      if (!busy_m) break;
      busy_cyc++;
      if (done_m) done_cnt++;
      if (prev_scl && s_scl && (s_sda != prev_sda)) begin
        if (!s_sda) start_cnt++;
        else stop_cnt++;
      end
      if (!prev_scl && s_scl) begin
        hi_cnt = 1;
        hi_valid = 1'b1;
        if (bit_idx < 8) begin
          cur = {cur[6:0], s_sda};
          bit_idx++;
          if (bit_idx == 8 && rx_n < 4) begin
            rx[rx_n] = cur;
            rx_n++;
          end
        end else begin
          bit_idx = 0;
        end
      end else if (prev_scl && s_scl) begin
        hi_cnt++;
      end
      if (prev_scl && !s_scl) begin
        if (hi_valid) begin
          if (hi_cnt < hi_min) hi_min = hi_cnt;
          if (hi_cnt > hi_max) hi_max = hi_cnt;
        end
        codec_pull = (bit_idx == 8) && (rx_n != nack_slot);
      end
      prev_scl = s_scl;
      prev_sda = s_sda;
      if (spam) begin
        data_drv = 16'hFFFF;
        start_drv = (busy_cyc % 16 == 8);
      end
      if (busy_cyc > 3000) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk_i2c);
    end
    done_end = done_m;
    start_drv = 1'b0;
    codec_pull = 1'b0;
    if (chain) begin
      data_drv = chain_d;
      start_drv = 1'b1;
    end
  endtask

  task automatic test_reset;
    reg_rstn = 1'b0;
    use4 = 1'b1;
    repeat (3) @(negedge clk_i2c);
    vec++; if (bus4.busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", bus4.busy_o); end
    vec++; if (bus4.done_o !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", bus4.done_o); end
    vec++; if (bus4.nack_o !== 1'b0) begin errs++; $display("FAIL rst_nack got %b want 0", bus4.nack_o); end
    vec++; if (scl4 !== 1'b1) begin errs++; $display("FAIL rst_scl got %b want 1", scl4); end
    vec++; if (sda_low4 !== 1'b0) begin errs++; $display("FAIL rst_sda_low got %b want 0", sda_low4); end
    vec++; if (scl1 !== 1'b1 || bus1.busy_o !== 1'b0) begin errs++; $display("FAIL rst_div1 scl/busy got %b%b want 10", scl1, bus1.busy_o); end
    reg_rstn = 1'b1;
    repeat (2) @(negedge clk_i2c);
  endtask

  task automatic test_latency_div1;
    use4 = 1'b0;
    @(negedge clk_i2c);
    xfer(16'h1E00, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vec++; if (timed_out !== 1'b0) begin errs++; $display("FAIL lat_timeout got %b want 0", timed_out); end
    vec++; if (first_busy !== 1'b1) begin errs++; $display("FAIL lat_busy_rise got %b want 1", first_busy); end
    vec++; if (rx_n !== 3) begin errs++; $display("FAIL lat_nbytes got %0d want 3", rx_n); end
    vec++; if (rx[0] !== 8'h34) begin errs++; $display("FAIL lat_byte0 got %h want 34", rx[0]); end
    vec++; if (rx[1] !== 8'h1E) begin errs++; $display("FAIL lat_byte1 got %h want 1e", rx[1]); end
    vec++; if (rx[2] !== 8'h00) begin errs++; $display("FAIL lat_byte2 got %h want 00", rx[2]); end
    vec++; if (busy_cyc !== 117) begin errs++; $display("FAIL lat_busy_cycles got %0d want 117", busy_cyc); end
    vec++; if (done_cnt !== 0 || done_end !== 1'b1) begin errs++; $display("FAIL lat_done got %0d/%b want 0/1", done_cnt, done_end); end
    vec++; if (nack_m !== 1'b0) begin errs++; $display("FAIL lat_nack got %b want 0", nack_m); end
    @(negedge clk_i2c);
    vec++; if (done_m !== 1'b0) begin errs++; $display("FAIL lat_done_width got %b want 0", done_m); end
    use4 = 1'b1;
    @(negedge clk_i2c);
  endtask

  task automatic test_timing_div4;
    xfer(16'h0C02, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vec++; if (start_cnt !== 1) begin errs++; $display("FAIL tim_sda_fall_scl_hi got %0d want 1", start_cnt); end
    vec++; if (stop_cnt !== 1) begin errs++; $display("FAIL tim_sda_rise_scl_hi got %0d want 1", stop_cnt); end
    vec++; if (hi_min !== 8 || hi_max !== 8) begin errs++; $display("FAIL tim_scl_high got %0d..%0d want 8", hi_min, hi_max); end
    vec++; if (busy_cyc !== 465) begin errs++; $display("FAIL tim_busy_cycles got %0d want 465", busy_cyc); end
    vec++; if (rx_n !== 3 || rx[0] !== 8'h34 || rx[1] !== 8'h0C || rx[2] !== 8'h02) begin
      errs++; $display("FAIL tim_bytes got %0d:%h %h %h want 3:34 0c 02", rx_n, rx[0], rx[1], rx[2]);
    end
    vec++; if (done_end !== 1'b1) begin errs++; $display("FAIL tim_done got %b want 1", done_end); end
    @(negedge clk_i2c);
  endtask

  task automatic test_nack;
    xfer(16'hA55A, 2, 1'b0, 1'b0, 1'b0, 16'h0000);
    vec++; if (rx_n !== 2 || rx[0] !== 8'h34 || rx[1] !== 8'hA5) begin
      errs++; $display("FAIL nack_bytes got %0d:%h %h want 2:34 a5", rx_n, rx[0], rx[1]);
    end
    vec++; if (stop_cnt !== 1) begin errs++; $display("FAIL nack_stop got %0d want 1", stop_cnt); end
    vec++; if (busy_cyc !== 321) begin errs++; $display("FAIL nack_busy_cycles got %0d want 321", busy_cyc); end
    vec++; if (done_end !== 1'b0 || done_cnt !== 0) begin errs++; $display("FAIL nack_done got %b/%0d want 0/0", done_end, done_cnt); end
    vec++; if (nack_m !== 1'b1) begin errs++; $display("FAIL nack_flag got %b want 1", nack_m); end
    repeat (5) @(negedge clk_i2c);
    vec++; if (nack_m !== 1'b1 || done_m !== 1'b0) begin errs++; $display("FAIL nack_sticky got %b/%b want 1/0", nack_m, done_m); end
    xfer(16'h1234, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vec++; if (first_nack !== 1'b0) begin errs++; $display("FAIL nack_clear_on_accept got %b want 0", first_nack); end
    vec++; if (rx_n !== 3 || rx[1] !== 8'h12 || rx[2] !== 8'h34) begin
      errs++; $display("FAIL nack_retry_bytes got %0d:%h %h want 3:12 34", rx_n, rx[1], rx[2]);
    end
    vec++; if (done_end !== 1'b1 || nack_m !== 1'b0) begin errs++; $display("FAIL nack_retry_done got %b/%b want 1/0", done_end, nack_m); end
    @(negedge clk_i2c);
  endtask

  task automatic test_start_ignored;
    xfer(16'h5A3C, 0, 1'b1, 1'b0, 1'b0, 16'h0000);
    vec++; if (rx_n !== 3 || rx[0] !== 8'h34 || rx[1] !== 8'h5A || rx[2] !== 8'h3C) begin
      errs++; $display("FAIL spam_bytes got %0d:%h %h %h want 3:34 5a 3c", rx_n, rx[0], rx[1], rx[2]);
    end
    vec++; if (busy_cyc !== 465) begin errs++; $display("FAIL spam_busy_cycles got %0d want 465", busy_cyc); end
    vec++; if (done_cnt !== 0 || done_end !== 1'b1) begin errs++; $display("FAIL spam_done got %0d/%b want 0/1", done_cnt, done_end); end
    @(negedge clk_i2c);
    vec++; if (done_m !== 1'b0 || busy_m !== 1'b0) begin errs++; $display("FAIL spam_after got %b/%b want 0/0", done_m, busy_m); end
  endtask

  task automatic test_reset_mid;
    data_drv = 16'h1E00;
    start_drv = 1'b1;
    @(negedge clk_i2c);
    start_drv = 1'b0;
    repeat (81) @(negedge clk_i2c);
    // Device byte, bit weight 3 (value 0), first quarter: SCL low, SDA pulled.
    vec++; if (busy_m !== 1'b1 || scl_m !== 1'b0 || sda_low_m !== 1'b1) begin
      errs++; $display("FAIL mid_pre busy/scl/sda_low got %b%b%b want 101", busy_m, scl_m, sda_low_m);
    end
    reg_rstn = 1'b0;
    #1;
    vec++; if (busy_m !== 1'b0) begin errs++; $display("FAIL mid_rst_busy got %b want 0", busy_m); end
    vec++; if (scl_m !== 1'b1) begin errs++; $display("FAIL mid_rst_scl got %b want 1", scl_m); end
    vec++; if (sda_low_m !== 1'b0) begin errs++; $display("FAIL mid_rst_sda_low got %b want 0", sda_low_m); end
    vec++; if (nack_m !== 1'b0 || done_m !== 1'b0) begin errs++; $display("FAIL mid_rst_flags got %b/%b want 0/0", nack_m, done_m); end
    @(negedge clk_i2c);
    reg_rstn = 1'b1;
    @(negedge clk_i2c);
    xfer(16'h0C02, 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    vec++; if (rx_n !== 3 || rx[0] !== 8'h34 || rx[1] !== 8'h0C || rx[2] !== 8'h02) begin
      errs++; $display("FAIL mid_restart_bytes got %0d:%h %h %h want 3:34 0c 02", rx_n, rx[0], rx[1], rx[2]);
    end
    vec++; if (busy_cyc !== 465 || done_end !== 1'b1) begin errs++; $display("FAIL mid_restart_done got %0d/%b want 465/1", busy_cyc, done_end); end
    @(negedge clk_i2c);
  endtask

  task automatic test_back_to_back;
    xfer(16'h1111, 0, 1'b0, 1'b0, 1'b1, 16'h2222);
    vec++; if (done_end !== 1'b1 || rx[1] !== 8'h11) begin errs++; $display("FAIL b2b_first got %b/%h want 1/11", done_end, rx[1]); end
    xfer(16'h2222, 0, 1'b0, 1'b1, 1'b0, 16'h0000);
    vec++; if (first_busy !== 1'b1) begin errs++; $display("FAIL b2b_gap busy after one idle cycle got %b want 1", first_busy); end
    vec++; if (rx_n !== 3 || rx[0] !== 8'h34 || rx[1] !== 8'h22 || rx[2] !== 8'h22) begin
      errs++; $display("FAIL b2b_bytes got %0d:%h %h %h want 3:34 22 22", rx_n, rx[0], rx[1], rx[2]);
    end
    vec++; if (done_end !== 1'b1 || timed_out !== 1'b0) begin errs++; $display("FAIL b2b_done got %b/%b want 1/0", done_end, timed_out); end
    @(negedge clk_i2c);
  endtask

  initial begin
    test_reset();
    test_latency_div1();
    test_timing_div4();
    test_nack();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
